s_cla_pipe: RTL and testbench

S_CLA_PIPE -- requirements
Module: s_cla_pipe

---
 rtl/s_cla_pipe.sv | 131 +++++++++++++
 tb/tb_s_cla_pipe.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/s_cla_pipe.sv
// rtl/s_cla_pipe.sv - two-stage pipelined carry-lookahead adder/subtractor with valid/ready flow control
// Optional S_CLA_PIPE_SAT_EN: saturate sum on signed overflow.
module s_cla_pipe #(
    parameter int WIDTH = 24,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NG = WIDTH / GROUP;

    logic             ready_en_q;
    logic             s1_valid_q, s1_valid_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] p_q, g_q, p_d, g_d;
    logic             c0_q, c0_d;
    logic [NG-1:0]    gp_q, gg_q, gp_d, gg_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
`ifdef S_CLA_PIPE_SAT_EN
    logic             a_msb_q;
`endif

    logic s2_ready, s1_advance, in_fire;

    // ready_en_q keeps in_ready low until the first edge after reset release
    assign s2_ready   = !s2_valid_q || out_ready;
    assign s1_advance = s1_valid_q && s2_ready;
    assign in_ready   = ready_en_q && (!s1_valid_q || s1_advance);
    assign in_fire    = in_valid && in_ready;
    assign s1_valid_d = in_fire || (s1_valid_q && !s1_advance);
    assign s2_valid_d = s1_advance || (s2_valid_q && !out_ready);

    assign out_valid = s2_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

    always_comb begin : stage1
        logic [WIDTH-1:0] b_eff;
        b_eff = sub ? ~b : b;
        p_d   = a ^ b_eff;
        g_d   = a & b_eff;
        c0_d  = sub | cin;
        gp_d  = '1;
        gg_d  = '0;
        for (int k = 0; k < NG; k++) begin
            for (int j = 0; j < GROUP; j++) begin
                gp_d[k] = gp_d[k] & p_d[k*GROUP+j];
                gg_d[k] = g_d[k*GROUP+j] | (p_d[k*GROUP+j] & gg_d[k]);
            end
        end
    end

    always_comb begin : stage2
        logic [NG:0]    cg;
        logic [WIDTH:0] c;
        cg    = '0;
        c     = '0;
        cg[0] = c0_q;
        for (int k = 0; k < NG; k++) begin
            cg[k+1] = gg_q[k] | (gp_q[k] & cg[k]);
        end
        // Group-boundary carries from the lookahead override the in-group ripple value
        for (int k = 0; k < NG; k++) begin
            c[k*GROUP] = cg[k];
            for (int j = 0; j < GROUP; j++) begin
                c[k*GROUP+j+1] = g_q[k*GROUP+j] | (p_q[k*GROUP+j] & c[k*GROUP+j]);
            end
        end
        c[WIDTH] = cg[NG];
        sum_d  = p_q ^ c[WIDTH-1:0];
        cout_d = c[WIDTH];
        ovf_d  = c[WIDTH] ^ c[WIDTH-1];
`ifdef S_CLA_PIPE_SAT_EN
        if (ovf_d) begin
            sum_d = a_msb_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_q <= 1'b0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            p_q        <= '0;
            g_q        <= '0;
            c0_q       <= 1'b0;
            gp_q       <= '0;
            gg_q       <= '0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
            ovf_q      <= 1'b0;
`ifdef S_CLA_PIPE_SAT_EN
            a_msb_q    <= 1'b0;
`endif
        end else begin
            ready_en_q <= 1'b1;
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            if (in_fire) begin
                p_q  <= p_d;
                g_q  <= g_d;
                c0_q <= c0_d;
                gp_q <= gp_d;
                gg_q <= gg_d;
`ifdef S_CLA_PIPE_SAT_EN
                a_msb_q <= a[WIDTH-1];
`endif
            end
            if (s1_advance) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
            end
        end
    end
endmodule

// File: tb/tb_s_cla_pipe.sv
// tb/tb_s_cla_pipe.sv - randomized scoreboard bench for s_cla_pipe against a signed-arithmetic model
module tb_s_cla_pipe;
    localparam int WIDTH = 24;
    localparam int GROUP = 4;
    localparam longint FULL = longint'(1) << WIDTH;
    localparam longint HALF = FULL >> 1;
    localparam longint MAXS = HALF - 1;
    localparam longint MINS = -HALF;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a, b;
    logic             cin, sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout, ovf;

    s_cla_pipe #(.WIDTH(WIDTH), .GROUP(GROUP)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int delivered = 0;
    logic [WIDTH+1:0] exp_q[$];
    logic             hold_prev = 1'b0;
    logic [WIDTH+1:0] held_prev = '0;

    localparam logic [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Returns {ovf, cout, sum} from plain signed/unsigned arithmetic
    function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                               input logic ci, input logic sb);
        longint ux, uy, sx, sy, res;
        logic co, ov;
        logic [WIDTH-1:0] s;
        ux = longint'(x);
        uy = longint'(y);
        sx = (ux >= HALF) ? ux - FULL : ux;
        sy = (uy >= HALF) ? uy - FULL : uy;
        if (sb) begin
            res = sx - sy;
            co  = (ux >= uy);
        end else begin
            res = sx + sy + longint'(ci);
            co  = (ux + uy + longint'(ci)) >= FULL;
        end
        ov = (res > MAXS) || (res < MINS);
        s  = res[WIDTH-1:0];
`ifdef S_CLA_PIPE_SAT_EN
        if (ov) s = (res > 0) ? MAXV : MINV;
`endif
        return {ov, co, s};
    endfunction

    function automatic logic [WIDTH-1:0] pick();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return MINV;
            3:       return MAXV;
            default: return r[WIDTH-1:0];
        endcase
    endfunction

    task automatic step(input logic iv, input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                        input logic ic, input logic is, input logic ordy, output logic acc);
        @(negedge clk);
        in_valid  = iv;
        a         = ia;
        b         = ib;
        cin       = ic;
        sub       = is;
        out_ready = ordy;
        #1;
        if (hold_prev) check("hold", 64'({ovf, cout, sum}), 64'(held_prev));
        check("in_ready", 64'(in_ready), 64'((exp_q.size() < 2) || out_ready));
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious", 64'(1), 64'(0));
            end else begin
                check("result", 64'({ovf, cout, sum}), 64'(exp_q.pop_front()));
                delivered++;
            end
        end
        acc = in_valid && in_ready;
        if (acc) exp_q.push_back(model(ia, ib, ic, is));
        hold_prev = out_valid && !out_ready;
        held_prev = {ovf, cout, sum};
    endtask

    task automatic idle(input logic ordy);
        logic acc;
        step(1'b0, '0, '0, 1'b0, 1'b0, ordy, acc);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1'b1);
        check("drain_empty", 64'(exp_q.size()), 64'(0));
        idle(1'b1);
        idle(1'b1);
    endtask

    task automatic directed(input string tag, input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                            input logic ic, input logic is, input logic [WIDTH-1:0] es,
                            input logic ec, input logic eo);
        logic acc;
        step(1'b1, ia, ib, ic, is, 1'b1, acc);
        check({tag, "_acc"}, 64'(acc), 64'(1));
        idle(1'b1);
        check({tag, "_lat1"}, 64'(out_valid), 64'(0));
        idle(1'b1);
        check({tag, "_lat2"}, 64'(out_valid), 64'(1));
        check({tag, "_sum"}, 64'(sum), 64'(es));
        check({tag, "_cout"}, 64'(cout), 64'(ec));
        check({tag, "_ovf"}, 64'(ovf), 64'(eo));
        drain();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_outs", 64'({sum, cout, ovf}), 64'(0));
        exp_q.delete();
        hold_prev = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready_low", 64'(in_ready), 64'(0));
        @(posedge clk);
        #1;
        check("rel_in_ready_high", 64'(in_ready), 64'(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        int   sent, d0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b0;
        do_reset();

`ifdef S_CLA_PIPE_SAT_EN
        directed("max_plus_one", MAXV, ONE, 1'b0, 1'b0, MAXV, 1'b0, 1'b1);
        directed("min_minus_one", MINV, ONE, 1'b0, 1'b1, MINV, 1'b1, 1'b1);
`else
        directed("max_plus_one", MAXV, ONE, 1'b0, 1'b0, MINV, 1'b0, 1'b1);
        directed("min_minus_one", MINV, ONE, 1'b0, 1'b1, MAXV, 1'b1, 1'b1);
`endif
        directed("full_chain", '1, '0, 1'b1, 1'b0, '0, 1'b1, 1'b0);

        // Back-to-back beats with downstream stalled in cycles 2..6
        sent = 0;
        d0   = delivered;
        for (int c = 0; c < 40 && sent < 8; c++) begin
            step(1'b1, pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 !(c >= 2 && c <= 6), acc);
            if (acc) sent++;
        end
        check("stall_sent", 64'(sent), 64'(8));
        drain();
        check("stall_delivered", 64'(delivered - d0), 64'(8));

        // Reset with two beats in flight
        step(1'b1, pick(), pick(), 1'b0, 1'b0, 1'b0, acc);
        step(1'b1, pick(), pick(), 1'b0, 1'b1, 1'b0, acc);
        idle(1'b0);
        @(posedge clk);
        #2;
        do_reset();
        d0 = delivered;
        directed("post_reset", 'h5, 'h3, 1'b0, 1'b1, 'h2, 1'b1, 1'b0);
        check("post_reset_count", 64'(delivered - d0), 64'(1));

        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 3) != 0, pick(), pick(), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7, acc);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
